// File: rtl/rf_wr_arbiter_if.sv
// Request-side bundle for rf_wr_arbiter: two requesters (A and B), each with
// req/lock/addr/data toward the arbiter and an ack back from it.
//
// Handshake (both requesters): x_req high means a beat is offered. x_ack is
// combinational, high in the same cycle the arbiter accepts the beat. The
// beat transfers on every rising edge where x_req=1 and x_ack=1. While
// x_req=1 and x_ack=0, the requester holds x_lock/x_addr/x_data stable.
interface rf_wr_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 16
);
  logic          a_req;
  logic          a_lock;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          a_ack;
  logic          b_req;
  logic          b_lock;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          b_ack;

  modport master (
    output a_req, a_lock, a_addr, a_data,
    output b_req, b_lock, b_addr, b_data,
    input  a_ack, b_ack
  );

  modport slave (
    input  a_req, a_lock, a_addr, a_data,
    input  b_req, b_lock, b_addr, b_data,
    output a_ack, b_ack
  );
endinterface

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares one register-file write port between requesters A
// and B. The arbiter grants one beat per cycle, acks it combinationally, and
// drives Rw/Wdat/WrEn from registers one cycle later. A requester may hold
// the port for up to MAX_BURST consecutive beats by asserting lock.
//
// Build option: define RF_ARB_RR_EN for round-robin tie breaking in IDLE;
// without it, IDLE ties always go to A.
module rf_wr_arbiter #(
  parameter int AW        = 4,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  rf_wr_arbiter_if.slave req_if,
  output logic [AW-1:0] Rw,
  output logic [DW-1:0] Wdat,
  output logic          WrEn,
  output logic [1:0]    owner,
  output logic [1:0]    dbg_state,
  output logic [3:0]    dbg_cnt,
  output logic          dbg_lg
);

  // Encoding doubles as the owner code: 00 none, 01 A, 10 B.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  localparam logic [4:0] BURST_LIM = 5'(MAX_BURST);

  state_t        state;
  state_t        state_next;
  logic [3:0]    cnt;
  logic [3:0]    cnt_next;
  logic          lg;        // last granted requester: 0 = A, 1 = B
  logic          grant_a;
  logic          grant_b;
  logic          sel_lock;
  logic [4:0]    beats;     // beats in the current lock run including this one
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  // Grant selection: a live owner wins outright; otherwise IDLE rules apply,
  // which also covers the cycle in which an owner drops its request.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == OWN_A && req_if.a_req) begin
      grant_a = 1'b1;
    end else if (state == OWN_B && req_if.b_req) begin
      grant_b = 1'b1;
    end else if (req_if.a_req && req_if.b_req) begin
`ifdef RF_ARB_RR_EN
      grant_a = lg;
      grant_b = ~lg;
`else
      grant_a = 1'b1;
`endif
    end else begin
      grant_a = req_if.a_req;
      grant_b = req_if.b_req;
    end
  end

  // Acks are held low while reset is asserted, even if requests are present.
  assign req_if.a_ack = grant_a & rst_n;
  assign req_if.b_ack = grant_b & rst_n;

  // Next state and burst count: a lock run continues only for the requester
  // that already owns the port; any other grant starts counting from zero.
  always_comb begin
    state_next = IDLE;
    cnt_next   = 4'd0;
    sel_lock   = 1'b0;
    beats      = 5'd0;
    sel_addr   = req_if.a_addr;
    sel_data   = req_if.a_data;
    if (grant_a) begin
      sel_lock = req_if.a_lock;
      beats    = (state == OWN_A) ? ({1'b0, cnt} + 5'd1) : 5'd1;
    end else if (grant_b) begin
      sel_lock = req_if.b_lock;
      sel_addr = req_if.b_addr;
      sel_data = req_if.b_data;
      beats    = (state == OWN_B) ? ({1'b0, cnt} + 5'd1) : 5'd1;
    end
    if ((grant_a || grant_b) && sel_lock && (beats < BURST_LIM)) begin
      state_next = grant_a ? OWN_A : OWN_B;
      cnt_next   = beats[3:0];
    end
  end

  // Lock state and burst counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // RF write-port register: capture the granted beat, hold address/data
  // when idle, and remember who was granted last for tie breaking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WrEn <= 1'b0;
      Rw   <= '0;
      Wdat <= '0;
      lg   <= 1'b1;
    end else if (grant_a || grant_b) begin
      WrEn <= 1'b1;
      Rw   <= sel_addr;
      Wdat <= sel_data;
      lg   <= grant_b;
    end else begin
      WrEn <= 1'b0;
    end
  end

  assign owner     = state;
  assign dbg_state = state;
  assign dbg_cnt   = cnt;
  assign dbg_lg    = lg;

endmodule
